// File: rtl/gnr_sim_ctrl.sv
// Run controller for a Boolean gene-regulatory network node array: loads an
// initial state, steps tortoise/hare copies and stops on a Floyd meet or step limit.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; init_vec captured on start
// LOAD  | one cycle of reset_nos so every node loads init_state
// RUN   | one hare/tortoise step per cycle until meet or MAX_STEPS
// DONE  | result held on result_* until result_ready
module gnr_sim_ctrl #(
    parameter int N_NODES   = 8,
    parameter int STEP_W    = 16,
    parameter int MAX_STEPS = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_vec,
    output logic               busy,
    output logic               reset_nos,
    output logic               start_s0,
    output logic               start_s1,
    output logic [N_NODES-1:0] init_state,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [STEP_W-1:0]  result_steps,
    output logic [N_NODES-1:0] result_state,
    output logic               result_timeout
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;

    localparam logic [STEP_W-1:0] MAX_CNT = STEP_W'(MAX_STEPS);

    state_t             state_q, state_d;
    logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
    logic [N_NODES-1:0] init_state_q, init_state_d;
    logic [STEP_W-1:0]  res_steps_q, res_steps_d;
    logic [N_NODES-1:0] res_state_q, res_state_d;
    logic               res_timeout_q, res_timeout_d;
    logic               busy_q, busy_d;
    logic               reset_nos_q, reset_nos_d;
    logic               res_valid_q, res_valid_d;

    logic attractor;
    logic limit_hit;
    logic step_en;

    // The step strobes decode the live node compare so the array advances one
    // hare step per RUN cycle; the node vectors are themselves registered.
    assign attractor = (state_q == ST_RUN) && (step_cnt_q != '0) && (s0_vec == s1_vec);
    assign limit_hit = (state_q == ST_RUN) && (step_cnt_q == MAX_CNT);
    assign step_en   = (state_q == ST_RUN) && !attractor && !limit_hit;

    always_comb begin
        state_d       = state_q;
        step_cnt_d    = step_cnt_q;
        init_state_d  = init_state_q;
        res_steps_d   = res_steps_q;
        res_state_d   = res_state_q;
        res_timeout_d = res_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    init_state_d = init_vec;
                    step_cnt_d   = '0;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
                if (attractor) begin
                    res_steps_d   = step_cnt_q;
                    res_state_d   = s1_vec;
                    res_timeout_d = 1'b0;
                    state_d       = ST_DONE;
                end else if (limit_hit) begin
                    res_steps_d   = step_cnt_q;
                    res_state_d   = s1_vec;
                    res_timeout_d = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    step_cnt_d = step_cnt_q + STEP_W'(1);
                end
            end
            ST_DONE: begin
                if (result_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d      = (state_d != ST_IDLE);
        reset_nos_d = (state_d == ST_LOAD);
        res_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            step_cnt_q    <= '0;
            init_state_q  <= '0;
            res_steps_q   <= '0;
            res_state_q   <= '0;
            res_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            reset_nos_q   <= 1'b0;
            res_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_cnt_q    <= step_cnt_d;
            init_state_q  <= init_state_d;
            res_steps_q   <= res_steps_d;
            res_state_q   <= res_state_d;
            res_timeout_q <= res_timeout_d;
            busy_q        <= busy_d;
            reset_nos_q   <= reset_nos_d;
            res_valid_q   <= res_valid_d;
        end
    end

    assign busy           = busy_q;
    assign reset_nos      = reset_nos_q;
    assign start_s0       = step_en;
    assign start_s1       = step_en;
    assign init_state     = init_state_q;
    assign result_valid   = res_valid_q;
    assign result_steps   = res_steps_q;
    assign result_state   = res_state_q;
    assign result_timeout = res_timeout_q;

endmodule

// File: tb/tb_gnr_sim_ctrl.sv
// Directed bench for gnr_sim_ctrl with a behavioural node array that steps the
// tortoise once and the hare twice per strobe.
module tb_gnr_sim_ctrl;

    localparam int N = 8;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  init_vec = '0;
    logic          busy, reset_nos, start_s0, start_s1;
    logic [N-1:0]  init_state;
    logic [N-1:0]  s0_r = '0;
    logic [N-1:0]  s1_r = '0;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic [SW-1:0] result_steps;
    logic [N-1:0]  result_state;
    logic          result_timeout;

    int mode = 0;
    int n_checks = 0;
    int n_fail = 0;
    int overlap_err = 0;

    gnr_sim_ctrl #(.N_NODES(N), .STEP_W(SW), .MAX_STEPS(20)) dut (
        .clk(clk), .rst(rst), .start(start), .init_vec(init_vec),
        .busy(busy), .reset_nos(reset_nos), .start_s0(start_s0), .start_s1(start_s1),
        .init_state(init_state), .s0_vec(s0_r), .s1_vec(s1_r),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_steps(result_steps), .result_state(result_state),
        .result_timeout(result_timeout)
    );

    always #5 clk = ~clk;

    // 0 identity, 1 toggle bit 0, 2 increment mod 256, 3 increment mod 20
    function automatic logic [N-1:0] f_next(input int m, input logic [N-1:0] x);
        case (m)
            0:       return x;
            1:       return x ^ 8'h01;
            2:       return x + 8'd1;
            default: return (x == 8'd19) ? 8'd0 : x + 8'd1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset_nos) begin
            s0_r <= init_state;
            s1_r <= init_state;
        end else begin
            if (start_s0) s0_r <= f_next(mode, s0_r);
            if (start_s1) s1_r <= f_next(mode, f_next(mode, s1_r));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [N-1:0] init);
        @(negedge clk);
        init_vec = init;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where result_valid is first seen.
    task automatic wait_done(output int n_st, output int n_rn);
        bit ok;
        ok = 0;
        n_st = 0;
        n_rn = 0;
        for (int c = 0; c < 200; c++) begin
            if (result_valid) begin
                ok = 1;
                break;
            end
            if (reset_nos) n_rn++;
            if (start_s0) n_st++;
            if ((reset_nos && start_s0) || (start_s0 != start_s1)) overlap_err++;
            @(negedge clk);
        end
        if (!ok) chk("done_wait", 32'd0, 32'd1);
    endtask

    task automatic release_result();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("rel_valid", 32'(result_valid), 32'd0);
        chk("rel_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=stuck expected=finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n_st, n_rn, seen;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_reset_nos", 32'(reset_nos), 32'd0);
        chk("rst_start_s0", 32'(start_s0), 32'd0);
        chk("rst_start_s1", 32'(start_s1), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_timeout", 32'(result_timeout), 32'd0);
        chk("rst_steps", 32'(result_steps), 32'd0);
        chk("rst_state", 32'(result_state), 32'd0);
        chk("rst_init_state", 32'(init_state), 32'd0);
        rst = 1'b0;

        // identity network
        mode = 0;
        launch(8'hA5);
        chk("id_busy_load", 32'(busy), 32'd1);
        wait_done(n_st, n_rn);
        chk("id_steps", 32'(result_steps), 32'd1);
        chk("id_state", 32'(result_state), 32'hA5);
        chk("id_timeout", 32'(result_timeout), 32'd0);
        chk("id_nstarts", 32'(n_st), 32'd1);
        chk("id_nreset", 32'(n_rn), 32'd1);
        chk("id_init_state", 32'(init_state), 32'hA5);
        release_result();

        // period-2 toggle on node 0
        mode = 1;
        launch(8'h00);
        wait_done(n_st, n_rn);
        chk("tg_steps", 32'(result_steps), 32'd2);
        chk("tg_state", 32'(result_state), 32'h00);
        chk("tg_timeout", 32'(result_timeout), 32'd0);
        chk("tg_nstarts", 32'(n_st), 32'd2);
        release_result();

        // never converging within the limit, then hold the result
        mode = 2;
        launch(8'h00);
        wait_done(n_st, n_rn);
        chk("to_steps", 32'(result_steps), 32'd20);
        chk("to_state", 32'(result_state), 32'h28);
        chk("to_timeout", 32'(result_timeout), 32'd1);
        chk("to_nstarts", 32'(n_st), 32'd20);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 32'(result_valid), 32'd1);
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_steps", 32'(result_steps), 32'd20);
            chk("hold_state", 32'(result_state), 32'h28);
            chk("hold_starts", 32'(start_s0 | start_s1 | reset_nos), 32'd0);
            if (i == 3) begin
                init_vec = 8'hFF;
                start = 1'b1;
            end
            if (i == 4) start = 1'b0;
            @(negedge clk);
        end
        chk("hold_init_state", 32'(init_state), 32'h00);
        release_result();

        // first meet coincides with the step limit: attractor wins
        mode = 3;
        launch(8'h00);
        wait_done(n_st, n_rn);
        chk("tie_steps", 32'(result_steps), 32'd20);
        chk("tie_state", 32'(result_state), 32'h00);
        chk("tie_timeout", 32'(result_timeout), 32'd0);
        chk("tie_nstarts", 32'(n_st), 32'd20);
        release_result();

        // reset during the fifth step
        mode = 2;
        launch(8'h00);
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            if (start_s0) seen++;
            if (seen == 5) break;
            @(negedge clk);
        end
        chk("mid_reach5", 32'(seen), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_starts", 32'(start_s0 | start_s1), 32'd0);
        chk("mid_valid", 32'(result_valid), 32'd0);
        mode = 0;
        launch(8'h3C);
        wait_done(n_st, n_rn);
        chk("post_steps", 32'(result_steps), 32'd1);
        chk("post_state", 32'(result_state), 32'h3C);
        chk("post_nreset", 32'(n_rn), 32'd1);
        release_result();

        // back-to-back with ready tied high
        result_ready = 1'b1;
        launch(8'h11);
        wait_done(n_st, n_rn);
        chk("b2b1_state", 32'(result_state), 32'h11);
        init_vec = 8'h22;
        start = 1'b1;
        @(negedge clk);
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_load_rnos", 32'(reset_nos), 32'd1);
        chk("b2b_load_init", 32'(init_state), 32'h22);
        wait_done(n_st, n_rn);
        chk("b2b2_steps", 32'(result_steps), 32'd1);
        chk("b2b2_state", 32'(result_state), 32'h22);
        @(negedge clk);
        chk("b2b2_valid_drop", 32'(result_valid), 32'd0);
        result_ready = 1'b0;

        chk("strobe_overlap", 32'(overlap_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
